// File: rtl/exp_acc_ctrl.sv
// exp_acc_ctrl: read-modify-write sequencer accumulating exp10 complex samples into an external RAM
// through an external adder. Build macro EXP_ACC_SAT_EN enables exponent-wrap saturation and exp_ovf.
module exp_acc_ctrl #(
   parameter int ADDR_WIDTH  = 7,
   parameter int ROUND_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [ROUND_WIDTH-1:0] acc_rounds,
   input  logic [ADDR_WIDTH-1:0]  depth_m1,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [9:0]             in_i,
   input  logic [9:0]             in_q,
   input  logic [3:0]             in_exp,
   output logic                   ram_rd_en,
   output logic [ADDR_WIDTH-1:0]  ram_rd_addr,
   input  logic [23:0]            ram_rd_data,
   output logic                   ram_wr_en,
   output logic [ADDR_WIDTH-1:0]  ram_wr_addr,
   output logic [23:0]            ram_wr_data,
   output logic [9:0]             add_in1_i,
   output logic [9:0]             add_in1_q,
   output logic [3:0]             add_in1_exp,
   output logic [9:0]             add_in2_i,
   output logic [9:0]             add_in2_q,
   output logic [3:0]             add_in2_exp,
   input  logic [9:0]             add_out_i,
   input  logic [9:0]             add_out_q,
   input  logic [3:0]             add_out_exp,
   output logic                   busy,
   output logic                   done,
   output logic                   exp_ovf
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_FLUSH = 2'd2, S_DONE = 2'd3} state_t;

   localparam logic [ADDR_WIDTH-1:0]  ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ROUND_WIDTH-1:0] ROUND_ZERO = {ROUND_WIDTH{1'b0}};
   localparam logic [ROUND_WIDTH-1:0] ROUND_ONE  = {{(ROUND_WIDTH-1){1'b0}}, 1'b1};

   state_t                 state_q, state_d;
   logic [ROUND_WIDTH-1:0] rounds_q, rounds_d, round_q, round_d;
   logic [ADDR_WIDTH-1:0]  depth_q, depth_d, ptr_q, ptr_d;
   logic                   s1_vld_q, s1_vld_d, s1_zero_q, s1_zero_d;
   logic [ADDR_WIDTH-1:0]  s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
   logic [23:0]            s1_smp_q, s1_smp_d, s2_data_q, s2_data_d;
   logic                   s2_vld_q, s2_vld_d;
   logic                   exp_ovf_q, exp_ovf_d;
   logic                   hazard_s, accept_s, last_s, wrap_s;
   logic [23:0]            op2_s, res_s;
`ifdef EXP_ACC_SAT_EN
   logic [23:0]            dom_s;

   // A zero component stays zero; otherwise pin to the full-scale value of its sign.
   function automatic logic [9:0] sat_mant(input logic [9:0] m);
      if (m == 10'd0) begin
         sat_mant = 10'd0;
      end else if (m[9]) begin
         sat_mant = 10'h200;
      end else begin
         sat_mant = 10'h1FF;
      end
   endfunction
`endif

   // Hazard check, adder operand steering and RAM/status outputs.
   always_comb begin
      hazard_s = (s1_vld_q && (s1_addr_q == ptr_q)) || (s2_vld_q && (s2_addr_q == ptr_q));
      in_ready = (state_q == S_ACC) && !hazard_s && !abort;
      accept_s = in_valid && in_ready;
      last_s   = (ptr_q == depth_q) && (round_q == (rounds_q - ROUND_ONE));
      // Pass 0 must not inherit whatever the RAM held before this run.
      op2_s    = (s1_vld_q && !s1_zero_q) ? ram_rd_data : 24'd0;
      {add_in1_i, add_in1_q, add_in1_exp} = s1_smp_q;
      {add_in2_i, add_in2_q, add_in2_exp} = op2_s;
      wrap_s   = 1'b0;
      res_s    = {add_out_i, add_out_q, add_out_exp};
`ifdef EXP_ACC_SAT_EN
      dom_s    = (s1_smp_q[3:0] >= op2_s[3:0]) ? s1_smp_q : op2_s;
      if (s1_vld_q && (add_out_exp < dom_s[3:0])) begin
         wrap_s = 1'b1;
         res_s  = {sat_mant(dom_s[23:14]), sat_mant(dom_s[13:4]), 4'd15};
      end else begin
         wrap_s = 1'b0;
      end
`endif
      ram_rd_en   = accept_s;
      ram_rd_addr = ptr_q;
      ram_wr_en   = s2_vld_q;
      ram_wr_addr = s2_addr_q;
      ram_wr_data = s2_data_q;
      busy        = (state_q == S_ACC) || (state_q == S_FLUSH);
      done        = (state_q == S_DONE);
      exp_ovf     = exp_ovf_q;
   end

   // Next-state logic for the sequencer and the two pipeline stages.
   always_comb begin
      state_d   = state_q;
      rounds_d  = rounds_q;
      depth_d   = depth_q;
      ptr_d     = ptr_q;
      round_d   = round_q;
      exp_ovf_d = exp_ovf_q | wrap_s;
      s1_vld_d  = accept_s;
      s1_addr_d = accept_s ? ptr_q : s1_addr_q;
      s1_smp_d  = accept_s ? {in_i, in_q, in_exp} : s1_smp_q;
      s1_zero_d = accept_s ? (round_q == ROUND_ZERO) : s1_zero_q;
      s2_vld_d  = s1_vld_q;
      s2_addr_d = s1_vld_q ? s1_addr_q : s2_addr_q;
      s2_data_d = s1_vld_q ? res_s : s2_data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               rounds_d  = (acc_rounds == ROUND_ZERO) ? ROUND_ONE : acc_rounds;
               depth_d   = depth_m1;
               ptr_d     = ADDR_ZERO;
               round_d   = ROUND_ZERO;
               exp_ovf_d = 1'b0;
               state_d   = S_ACC;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_ACC: begin
            if (accept_s) begin
               if (ptr_q == depth_q) begin
                  ptr_d   = ADDR_ZERO;
                  round_d = round_q + ROUND_ONE;
               end else begin
                  ptr_d   = ptr_q + ADDR_ONE;
               end
               state_d = last_s ? S_FLUSH : S_ACC;
            end else begin
               state_d = S_ACC;
            end
         end
         // Stage 2 issues its write this cycle, so only stage 1 must have drained.
         S_FLUSH: state_d = s1_vld_q ? S_FLUSH : S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer and pipeline registers; abort behaves exactly like reset here.
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         state_q   <= S_IDLE;
         rounds_q  <= ROUND_ZERO;
         depth_q   <= ADDR_ZERO;
         ptr_q     <= ADDR_ZERO;
         round_q   <= ROUND_ZERO;
         s1_vld_q  <= 1'b0;
         s1_zero_q <= 1'b0;
         s1_addr_q <= ADDR_ZERO;
         s1_smp_q  <= 24'd0;
         s2_vld_q  <= 1'b0;
         s2_addr_q <= ADDR_ZERO;
         s2_data_q <= 24'd0;
      end else begin
         state_q   <= state_d;
         rounds_q  <= rounds_d;
         depth_q   <= depth_d;
         ptr_q     <= ptr_d;
         round_q   <= round_d;
         s1_vld_q  <= s1_vld_d;
         s1_zero_q <= s1_zero_d;
         s1_addr_q <= s1_addr_d;
         s1_smp_q  <= s1_smp_d;
         s2_vld_q  <= s2_vld_d;
         s2_addr_q <= s2_addr_d;
         s2_data_q <= s2_data_d;
      end
   end

   // Sticky overflow flag survives abort.
   always_ff @(posedge clk) begin
      if (rst) begin
         exp_ovf_q <= 1'b0;
      end else if (abort) begin
         exp_ovf_q <= exp_ovf_q;
      end else begin
         exp_ovf_q <= exp_ovf_d;
      end
   end

endmodule

// File: tb/tb_exp_acc_ctrl.sv
// Self-checking bench for exp_acc_ctrl: behavioural RAM and adder around the DUT, reference
// accumulation model per address, directed and randomized runs. Honors EXP_ACC_SAT_EN if defined.
module tb_exp_acc_ctrl;
   localparam int AW = 7;
   localparam int RW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
   logic [RW-1:0] acc_rounds = '0;
   logic [AW-1:0] depth_m1 = '0;
   logic [9:0]    in_i = '0, in_q = '0;
   logic [3:0]    in_exp = '0;
   logic          in_ready, ram_rd_en, ram_wr_en, busy, done, exp_ovf;
   logic [AW-1:0] ram_rd_addr, ram_wr_addr;
   logic [23:0]   ram_rd_data = 24'd0;
   logic [23:0]   ram_wr_data;
   logic [9:0]    add_in1_i, add_in1_q, add_in2_i, add_in2_q, add_out_i, add_out_q;
   logic [3:0]    add_in1_exp, add_in2_exp, add_out_exp;
   logic          fill = 1'b0;
   logic [23:0]   mem [0:127];
   int            cyc = 0, done_cnt = 0, done_cyc = 0, wr_cnt = 0, rd_cnt = 0;
   int            n_cmp = 0, n_fail = 0;
   logic [23:0]   model [0:127];
   logic          model_ovf = 1'b0;
   int            last_acc = 0;

   always #5 clk = ~clk;

   exp_acc_ctrl #(.ADDR_WIDTH(AW), .ROUND_WIDTH(RW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .acc_rounds(acc_rounds), .depth_m1(depth_m1),
      .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q), .in_exp(in_exp),
      .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
      .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
      .add_in1_i(add_in1_i), .add_in1_q(add_in1_q), .add_in1_exp(add_in1_exp),
      .add_in2_i(add_in2_i), .add_in2_q(add_in2_q), .add_in2_exp(add_in2_exp),
      .add_out_i(add_out_i), .add_out_q(add_out_q), .add_out_exp(add_out_exp),
      .busy(busy), .done(done), .exp_ovf(exp_ovf)
   );

   // Exp-format complex add: align to the larger exponent, renormalise once on mantissa overflow.
   function automatic logic [23:0] add_fn(input logic [23:0] a, input logic [23:0] b);
      int ai, aq, bi, bq, ea, eb, e, si, sq;
      ai = $signed(a[23:14]); aq = $signed(a[13:4]); ea = int'(a[3:0]);
      bi = $signed(b[23:14]); bq = $signed(b[13:4]); eb = int'(b[3:0]);
      if (ea >= eb) begin
         e = ea; bi = bi >>> (ea - eb); bq = bq >>> (ea - eb);
      end else begin
         e = eb; ai = ai >>> (eb - ea); aq = aq >>> (eb - ea);
      end
      si = ai + bi; sq = aq + bq;
      if (si > 511 || si < -512 || sq > 511 || sq < -512) begin
         si = si >>> 1; sq = sq >>> 1; e = e + 1;
      end
      return {si[9:0], sq[9:0], e[3:0]};
   endfunction

   function automatic int clampv(input logic [9:0] m);
      int v;
      v = $signed(m);
      return (v > 0) ? 511 : ((v < 0) ? -512 : 0);
   endfunction

   // Expected new RAM value and overflow flag for one accumulation step.
   function automatic logic [24:0] ref_acc(input logic [23:0] prev, input logic [23:0] s);
      logic [23:0] r;
      logic        ovf;
      r   = add_fn(s, prev);
      ovf = 1'b0;
`ifdef EXP_ACC_SAT_EN
      begin
         logic [23:0] big;
         int ci, cq;
         big = (s[3:0] >= prev[3:0]) ? s : prev;
         if (r[3:0] < big[3:0]) begin
            ci = clampv(big[23:14]); cq = clampv(big[13:4]);
            r = {ci[9:0], cq[9:0], 4'd15};
            ovf = 1'b1;
         end
      end
`endif
      return {ovf, r};
   endfunction

   always_comb {add_out_i, add_out_q, add_out_exp} =
      add_fn({add_in1_i, add_in1_q, add_in1_exp}, {add_in2_i, add_in2_q, add_in2_exp});

   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 128; i++) mem[i] <= 24'($urandom);
      end else if (ram_wr_en) begin
         mem[ram_wr_addr] <= ram_wr_data;
      end
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (ram_wr_en) wr_cnt <= wr_cnt + 1;
      if (ram_rd_en) rd_cnt <= rd_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic start_cfg(input int d, input int r);
      depth_m1 = d[AW-1:0]; acc_rounds = r[RW-1:0]; start = 1'b1;
      tick();
      start = 1'b0;
      model_ovf = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("ovf_cleared_on_start", 32'(exp_ovf), 32'd0);
   endtask

   task automatic feed(input int d, input int r, input bit fixed, input logic [23:0] fs,
                       input bit gaps, input int stop_at, input bit start_mid, output int stalls);
      int          eff_r, n, k, guard, a;
      logic [23:0] s;
      logic [24:0] rr;
      logic [31:0] rv;
      eff_r = (r == 0) ? 1 : r;
      n = (d + 1) * eff_r;
      if (stop_at < n) n = stop_at;
      k = 0; guard = 0; stalls = 0;
      rv = $urandom; s = fixed ? fs : rv[23:0];
      while (k < n && guard < 4000) begin
         in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         {in_i, in_q, in_exp} = s;
         start = start_mid && (k == 2);
         if (start) begin
            depth_m1 = 7'd1; acc_rounds = 8'd5;
         end else begin
            depth_m1 = d[AW-1:0]; acc_rounds = r[RW-1:0];
         end
         if (in_valid && !in_ready) stalls++;
         if (in_valid && in_ready) begin
            a = k % (d + 1);
            rr = ref_acc((k <= d) ? 24'd0 : model[a], s);
            model[a] = rr[23:0];
            model_ovf = model_ovf | rr[24];
            last_acc = cyc;
            k++;
            rv = $urandom; s = fixed ? fs : rv[23:0];
         end
         tick();
         guard++;
      end
      in_valid = 1'b0; start = 1'b0;
      check("accepted_count", k, n);
   endtask

   task automatic full_run(input int d, input int r, input bit fixed, input logic [23:0] fs,
                           input bit gaps, input bit start_mid, output int stalls);
      int base, rd0, g, n;
      n = (d + 1) * ((r == 0) ? 1 : r);
      start_cfg(d, r);
      base = done_cnt; rd0 = rd_cnt;
      feed(d, r, fixed, fs, gaps, 1 << 20, start_mid, stalls);
      g = 0;
      while (done_cnt == base && g < 100) begin
         tick(); g++;
      end
      check("done_latency", done_cyc - last_acc, 3);
      repeat (3) tick();
      check("done_once", done_cnt - base, 1);
      check("busy_after_done", 32'(busy), 32'd0);
      check("read_count", rd_cnt - rd0, n);
      for (int a = 0; a <= d; a++) check("ram_entry", 32'(mem[a]), 32'(model[a]));
   endtask

   initial begin
      int st, base, w0, d, r;
      repeat (3) tick();
      check("rst_flags", 32'({in_ready, ram_rd_en, ram_wr_en, busy, done, exp_ovf}), 32'd0);
      check("rst_addr", 32'({ram_rd_addr, ram_wr_addr}), 32'd0);
      check("rst_wdata", 32'(ram_wr_data), 32'd0);
      check("rst_add1", 32'({add_in1_i, add_in1_q, add_in1_exp}), 32'd0);
      check("rst_add2", 32'({add_in2_i, add_in2_q, add_in2_exp}), 32'd0);
      rst = 1'b0; fill = 1'b1;
      tick();
      fill = 1'b0;
      tick();

      full_run(3, 1, 1'b1, {10'd10, 10'h3FB, 4'd2}, 1'b0, 1'b0, st);
      check("t1_stalls", st, 0);
      check("t1_entry0", 32'(mem[0]), 32'({10'd10, 10'h3FB, 4'd2}));
      check("t1_entry3", 32'(mem[3]), 32'({10'd10, 10'h3FB, 4'd2}));

      full_run(3, 2, 1'b1, {10'd10, 10'h3FB, 4'd2}, 1'b0, 1'b0, st);
      check("t2_stalls", st, 0);
      check("t2_entry1", 32'(mem[1]), 32'({10'd20, 10'h3F6, 4'd2}));

      full_run(0, 3, 1'b1, {10'd100, 10'd100, 4'd0}, 1'b0, 1'b0, st);
      check("t3_stalls", st, 4);
      check("t3_entry0", 32'(mem[0]), 32'({10'd300, 10'd300, 4'd0}));

      full_run(3, 1, 1'b0, 24'd0, 1'b0, 1'b1, st);

      start_cfg(3, 2);
      base = done_cnt;
      feed(3, 2, 1'b0, 24'd0, 1'b0, 6, 1'b0, st);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      w0 = wr_cnt;
      check("abort_busy", 32'(busy), 32'd0);
      repeat (5) tick();
      check("abort_no_write", wr_cnt - w0, 0);
      check("abort_no_done", done_cnt - base, 0);
      check("abort_not_ready", 32'(in_ready), 32'd0);
      full_run(5, 2, 1'b0, 24'd0, 1'b1, 1'b0, st);

      full_run(0, 2, 1'b1, {10'd511, 10'd0, 4'd15}, 1'b0, 1'b0, st);
`ifdef EXP_ACC_SAT_EN
      check("sat_entry", 32'(mem[0]), 32'({10'd511, 10'd0, 4'd15}));
      check("sat_ovf", 32'(exp_ovf), 32'd1);
`else
      check("raw_entry", 32'(mem[0]), 32'({10'd511, 10'd0, 4'd0}));
      check("raw_ovf", 32'(exp_ovf), 32'd0);
`endif
      repeat (4) tick();
      check("ovf_sticky", 32'(exp_ovf), 32'(model_ovf));

      for (int j = 0; j < 4; j++) begin
         d = $urandom_range(0, 12);
         r = $urandom_range(0, 3);
         full_run(d, r, 1'b0, 24'd0, 1'b1, 1'b0, st);
         check("rand_ovf", 32'(exp_ovf), 32'(model_ovf));
      end
      full_run(0, 1, 1'b0, 24'd0, 1'b0, 1'b0, st);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/exp_acc_ctrl.md
Name: exp_acc_ctrl

Overview:
- Sequences coherent accumulation of exp10-format complex correlation results into an external accumulation RAM.
- Uses one external complex exp-format adder (10-bit I/Q mantissa, 4-bit shared exponent) in a read-modify-write pipeline.
- Sits between the correlator output stream and the acquisition coherent buffer.
- Accumulates `acc_rounds` passes over `depth_m1+1` entries, then pulses `done`.

Parameters:
- ADDR_WIDTH, 7, accumulation RAM address width (max depth 128)
- ROUND_WIDTH, 8, width of round counter

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  pulse; latches config and begins accumulation when idle
- abort  input  1  synchronous abort to IDLE
- acc_rounds  input  ROUND_WIDTH  number of passes; 0 treated as 1
- depth_m1  input  ADDR_WIDTH  entries per pass minus one
- in_valid  input  1  sample valid
- in_ready  output  1  sample accepted when in_valid&in_ready
- in_i  input  10  sample I, two's complement
- in_q  input  10  sample Q
- in_exp  input  4  sample exponent
- ram_rd_en  output  1  RAM read strobe; data returned next cycle
- ram_rd_addr  output  ADDR_WIDTH  read address
- ram_rd_data  input  24  {i[9:0],q[9:0],exp[3:0]}
- ram_wr_en  output  1  RAM write strobe
- ram_wr_addr  output  ADDR_WIDTH  write address
- ram_wr_data  output  24  {i,q,exp}
- add_in1_i/add_in1_q/add_in1_exp  output  10/10/4  adder operand 1 (sample)
- add_in2_i/add_in2_q/add_in2_exp  output  10/10/4  adder operand 2 (RAM value)
- add_out_i/add_out_q/add_out_exp  input  10/10/4  adder combinational result
- busy  output  1  high from start accept until done/abort
- done  output  1  one-cycle completion pulse
- exp_ovf  output  1  sticky exponent overflow flag, cleared on start

Behaviour:
- Reset: state IDLE. `in_ready`, `ram_rd_en`, `ram_wr_en`, `busy`, `done` and `exp_ovf` are 0. All address and data outputs are 0.
- States are IDLE, ACC, FLUSH, DONE.
- IDLE: on `start`, latch `acc_rounds` (0→1) and `depth_m1`, set ptr=0 and round=0, clear `exp_ovf`, go to ACC. `start` in any other state is ignored.
- ACC: `in_ready`=1 unless the stage-1 or stage-2 pipeline holds a pending write to the current ptr (hazard stall; happens only when depth_m1<2).
- Accept at cycle T:
  - T: `ram_rd_en`=1, `ram_rd_addr`=ptr. Sample and ptr are registered into stage 1.
  - T+1: adder operands are driven.
    - Operand 1 is the stage-1 sample.
    - Operand 2 is `ram_rd_data`, or all-zero (i=q=0, exp=0) when round==0, so pass 0 overwrites stale RAM.
    - Adder result is registered into stage 2.
  - T+2: `ram_wr_en`=1, `ram_wr_addr`=stage-1 address, `ram_wr_data`=result.
- Throughput is one sample per cycle. A read of addr a+1 at T+1 never collides with the write of addr a at T+2.
- ptr wraps from `depth_m1` to 0 and increments round.
- After accepting the last entry of the last round, go to FLUSH with `in_ready`=0.
- FLUSH: wait until both pipeline stages are empty (last write issued), then go to DONE.
- DONE: `done`=1 for exactly one cycle, `busy`=0 from the same cycle, then IDLE.
- `busy` is 1 in ACC and FLUSH.
- abort (any state): next cycle is IDLE; pipeline valids are cleared, no further RAM writes, no `done`. Same effect as rst, except `exp_ovf` is held.
- Simultaneous `start` and `abort` in IDLE: abort wins.
- depth_m1=0 with acc_rounds=1: one sample, `done` at T+3.

Optional Feature:
- Macro: EXP_ACC_SAT_EN.
- Defined: exponent wrap is detected when add_out_exp < max(add_in1_exp, add_in2_exp). On wrap:
  - write exp=15;
  - write each mantissa clamped to +511 or -512, by the sign of the pre-sum dominant operand;
  - set `exp_ovf`.
- Undefined: the adder result is written unmodified and `exp_ovf` is tied 0.

Test Plan:
- depth_m1=3, acc_rounds=1, samples (10,-5,exp2) x4 → RAM entries 0..3 each = (10,-5,2); `done` 3 cycles after last accept; RAM pre-filled with garbage is ignored.
- depth_m1=3, acc_rounds=2, same sample repeated → each entry = (20,-10,2); `ram_rd_en` issued for round-1 addresses; zero stalls.
- depth_m1=0, acc_rounds=3, sample (100,100,0) → `in_ready` drops for 2 cycles between accepts; final entry (300,300,0); `done` once.
- abort asserted mid round 1 with 2 samples in flight → no `ram_wr_en` after the abort cycle, `busy`=0 next cycle, no `done`; a new `start` then works normally.
- With EXP_ACC_SAT_EN: RAM (511,0,15) plus sample (511,0,15) over 2 rounds → write (511,0,15), `exp_ovf`=1 until next start. Without the macro: raw adder result written, `exp_ovf`=0.
- `start` pulsed while `busy` → ignored, latched config unchanged.
